// File: rtl/elevator_car_plant_pkg.sv
// Shared constants and types for the two-car elevator plant model.
package elevator_car_plant_pkg;
   localparam int unsigned NUM_FLOORS = 6;
   localparam int unsigned NUM_CARS   = 2;
   localparam int unsigned LOC_W      = NUM_FLOORS / 2;

   localparam int unsigned DEF_TRAVEL_CYCLES = 8;
   localparam int unsigned DEF_DOOR_CYCLES   = 4;
   localparam int unsigned DEF_DWELL_CYCLES  = 10;

   typedef enum logic [2:0] {
      DOOR_OPEN,
      DOOR_CLOSING,
      IDLE_CLOSED,
      MOVING_UP,
      MOVING_DOWN,
      DOOR_OPENING
   } car_state_t;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction
endpackage

// File: rtl/elevator_car.sv
// One elevator car: motion/door FSM, shared phase counter and cabin request latch.
module elevator_car
   import elevator_car_plant_pkg::*;
#(
   parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES,
   parameter int unsigned DWELL_CYCLES  = DEF_DWELL_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  up,
   input  logic                  down,
   input  logic                  stop,
   input  logic [NUM_FLOORS-1:0] cabin_btn,
   output logic [LOC_W-1:0]      location,
   output logic                  door_closed,
   output logic [NUM_FLOORS-1:0] requested
);
   localparam int unsigned CNT_W = $clog2(max3(TRAVEL_CYCLES, DOOR_CYCLES, DWELL_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES);
   localparam logic [LOC_W-1:0] TOP_FLOOR   = LOC_W'(NUM_FLOORS - 1);

   car_state_t             state;
   logic [CNT_W-1:0]       cnt;
   logic                   stop_pend;
   logic                   cmd_up, cmd_dn, press, going_up, continue_move, opened;
   logic [LOC_W-1:0]       arrive_loc;
   logic [NUM_FLOORS-1:0]  floor_bit, req_set, req_clr;

   always_comb begin
      cmd_up        = up & ~down & ~stop;
      cmd_dn        = down & ~up & ~stop;
      floor_bit     = NUM_FLOORS'(1) << location;
      press         = |(cabin_btn & floor_bit);
      going_up      = (state == MOVING_UP);
      arrive_loc    = going_up ? location + LOC_W'(1) : location - LOC_W'(1);
      continue_move = going_up ? (cmd_up && arrive_loc != TOP_FLOOR)
                               : (cmd_dn && arrive_loc != '0);
      opened        = (state == DOOR_OPENING) && (cnt == '0);
      // A current-floor press while the door is not shut is served by the door, not latched
      req_set       = (state inside {DOOR_OPEN, DOOR_OPENING, DOOR_CLOSING})
                      ? (cabin_btn & ~floor_bit) : cabin_btn;
      req_clr       = opened ? floor_bit : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DOOR_OPEN;
         cnt         <= DWELL_LOAD;
         location    <= '0;
         door_closed <= 1'b0;
         requested   <= '0;
         stop_pend   <= 1'b0;
      end else begin
         requested <= (requested | req_set) & ~req_clr;
         case (state)
            DOOR_OPEN: begin
               if (press) cnt <= DWELL_LOAD;
               else if (cnt <= CNT_W'(1)) begin
                  state <= DOOR_CLOSING;
                  cnt   <= DOOR_LOAD;
               end else cnt <= cnt - CNT_W'(1);
            end
            DOOR_CLOSING: begin
               if (press || stop) begin
                  state <= DOOR_OPENING;
                  cnt   <= DOOR_LOAD;
               end else if (cnt == '0) begin
                  state       <= IDLE_CLOSED;
                  door_closed <= 1'b1;
               end else cnt <= cnt - CNT_W'(1);
            end
            IDLE_CLOSED: begin
               if (stop) begin
                  state       <= DOOR_OPENING;
                  cnt         <= DOOR_LOAD;
                  door_closed <= 1'b0;
               end else if (cmd_up && location != TOP_FLOOR) begin
                  state <= MOVING_UP;
                  cnt   <= TRAVEL_LOAD;
               end else if (cmd_dn && location != '0) begin
                  state <= MOVING_DOWN;
                  cnt   <= TRAVEL_LOAD;
               end
            end
            MOVING_UP, MOVING_DOWN: begin
               // stop is remembered across the transit and acted on only at arrival
               if (stop) stop_pend <= 1'b1;
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  location <= arrive_loc;
                  if (stop || stop_pend) begin
                     state       <= DOOR_OPENING;
                     cnt         <= DOOR_LOAD;
                     door_closed <= 1'b0;
                     stop_pend   <= 1'b0;
                  end else if (continue_move) cnt <= TRAVEL_LOAD;
                  else begin
                     state     <= IDLE_CLOSED;
                     stop_pend <= 1'b0;
                  end
               end
            end
            DOOR_OPENING: begin
               if (cnt == '0) begin
                  state <= DOOR_OPEN;
                  cnt   <= DWELL_LOAD;
               end else cnt <= cnt - CNT_W'(1);
            end
            default: begin
               state       <= DOOR_OPEN;
               cnt         <= DWELL_LOAD;
               door_closed <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/elevator_car_plant.sv
// Two-car plant model: one elevator_car per car, packing the buses MainController reads.
module elevator_car_plant
   import elevator_car_plant_pkg::*;
#(
   parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
   parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES,
   parameter int unsigned DWELL_CYCLES  = DEF_DWELL_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CARS-1:0]            up,
   input  logic [NUM_CARS-1:0]            down,
   input  logic [NUM_CARS-1:0]            stop,
   input  logic [NUM_CARS*NUM_FLOORS-1:0] cabin_btn,
   output logic [NUM_FLOORS-1:0]          elevators_location,
   output logic [NUM_CARS-1:0]            doors_status,
   output logic [NUM_CARS*NUM_FLOORS-1:0] requested_floors
);
   for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
      elevator_car #(
         .TRAVEL_CYCLES (TRAVEL_CYCLES),
         .DOOR_CYCLES   (DOOR_CYCLES),
         .DWELL_CYCLES  (DWELL_CYCLES)
      ) u_car (
         .clk         (clk),
         .rst_n       (rst_n),
         .up          (up[i]),
         .down        (down[i]),
         .stop        (stop[i]),
         .cabin_btn   (cabin_btn[i*NUM_FLOORS +: NUM_FLOORS]),
         .location    (elevators_location[i*LOC_W +: LOC_W]),
         .door_closed (doors_status[i]),
         .requested   (requested_floors[i*NUM_FLOORS +: NUM_FLOORS])
      );
   end
endmodule

// File: tb/tb_elevator_car_plant.sv
// Bench for elevator_car_plant: scenario tasks plus random traffic against a behavioural car model.
module tb_elevator_car_plant;
   localparam int TR = 4, DR = 2, DW = 3, NF = 6;
   localparam int D_OPEN = 0, D_CLOSING = 1, D_CLOSED = 2, D_OPENING = 3;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  up = '0, down = '0, stop = '0;
   logic [11:0] cabin_btn = '0;
   logic [5:0]  elevators_location;
   logic [1:0]  doors_status;
   logic [11:0] requested_floors;
   logic [19:0] dut_vec;

   int checks = 0, errors = 0;
   int m_loc[2], m_dir[2], m_prog[2], m_timer[2], m_door[2];
   bit m_pend[2];
   logic [11:0] m_req;

   always #5 clk = ~clk;
   assign dut_vec = {elevators_location, doors_status, requested_floors};

   elevator_car_plant #(.TRAVEL_CYCLES(TR), .DOOR_CYCLES(DR), .DWELL_CYCLES(DW)) dut (
      .clk(clk), .rst_n(rst_n), .up(up), .down(down), .stop(stop), .cabin_btn(cabin_btn),
      .elevators_location(elevators_location), .doors_status(doors_status),
      .requested_floors(requested_floors));

   function automatic void model_reset();
      for (int c = 0; c < 2; c++) begin
         m_loc[c] = 0; m_dir[c] = 0; m_prog[c] = 0; m_timer[c] = 0;
         m_door[c] = D_OPEN; m_pend[c] = 1'b0;
      end
      m_req = '0;
   endfunction

   // One clock of both cars: door positions with elapsed-time timers, motion as direction plus progress
   function automatic void model_step(input logic [1:0] u, input logic [1:0] d,
                                      input logic [1:0] s, input logic [11:0] b);
      for (int c = 0; c < 2; c++) begin
         bit cu, cd, st, press;
         cu = u[c] && !d[c] && !s[c];
         cd = d[c] && !u[c] && !s[c];
         st = s[c];
         press = b[c*NF + m_loc[c]];
         for (int f = 0; f < NF; f++)
            if (b[c*NF + f] && !(f == m_loc[c] && m_door[c] != D_CLOSED)) m_req[c*NF + f] = 1'b1;
         if (m_dir[c] != 0) begin
            if (st) m_pend[c] = 1'b1;
            m_prog[c]++;
            if (m_prog[c] == TR) begin
               m_loc[c] += m_dir[c];
               m_prog[c] = 0;
               if (m_pend[c]) begin
                  m_door[c] = D_OPENING; m_timer[c] = 0; m_dir[c] = 0; m_pend[c] = 1'b0;
               end else if (!(m_dir[c] > 0 ? (cu && m_loc[c] < NF-1) : (cd && m_loc[c] > 0))) begin
                  m_dir[c] = 0; m_pend[c] = 1'b0;
               end
            end
         end else begin
            case (m_door[c])
               D_OPEN: begin
                  if (press) m_timer[c] = 0;
                  else begin
                     m_timer[c]++;
                     if (m_timer[c] == DW) begin m_door[c] = D_CLOSING; m_timer[c] = 0; end
                  end
               end
               D_CLOSING: begin
                  if (press || st) begin m_door[c] = D_OPENING; m_timer[c] = 0; end
                  else begin
                     m_timer[c]++;
                     if (m_timer[c] == DR) m_door[c] = D_CLOSED;
                  end
               end
               D_CLOSED: begin
                  if (st) begin m_door[c] = D_OPENING; m_timer[c] = 0; end
                  else if (cu && m_loc[c] < NF-1) begin m_dir[c] = 1; m_prog[c] = 0; end
                  else if (cd && m_loc[c] > 0) begin m_dir[c] = -1; m_prog[c] = 0; end
               end
               default: begin
                  m_timer[c]++;
                  if (m_timer[c] == DR) begin
                     m_door[c] = D_OPEN; m_timer[c] = 0; m_req[c*NF + m_loc[c]] = 1'b0;
                  end
               end
            endcase
         end
      end
   endfunction

   function automatic logic [19:0] exp_vec();
      return {3'(m_loc[1]), 3'(m_loc[0]), m_door[1] == D_CLOSED, m_door[0] == D_CLOSED, m_req};
   endfunction

   task automatic tick();
      logic [1:0] u, d, s;
      logic [11:0] b;
      u = up; d = down; s = stop; b = cabin_btn;
      @(posedge clk);
      if (rst_n) model_step(u, d, s, b);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; up = '0; down = '0; stop = '0; cabin_btn = '0;
      #12;
      model_reset();
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL reset_values: got %h expected 0", dut_vec); end
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_close seq: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (doors_status !== 2'b11) begin errors++; $display("FAIL reset_door_closed: got %b expected 11", doors_status); end
   endtask

   task automatic test_move_up();
      int t = 0, open_t = -1;
      int change_t[$];
      logic [2:0] prev = '0;
      up[0] = 1'b1;
      for (int k = 0; k < 40 && !(m_loc[0] == 3 && m_door[0] == D_OPEN); k++) begin
         if (m_loc[0] == 2 && up[0]) begin up[0] = 1'b0; stop[0] = 1'b1; end
         else stop[0] = 1'b0;
         tick(); t++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL move_up: got %h expected %h", dut_vec, exp_vec()); end
         if (elevators_location[2:0] != prev) begin change_t.push_back(t); prev = elevators_location[2:0]; end
         if (m_loc[0] == 3 && m_door[0] == D_OPEN) open_t = t;
      end
      stop = '0; up = '0;
      checks++;
      if (change_t.size() != 3 || change_t[0] != 5 || change_t[1] != 9 || change_t[2] != 13) begin
         errors++; $display("FAIL move_up_step_times: got %p expected '{5,9,13}", change_t);
      end
      checks++;
      if (open_t != 15) begin errors++; $display("FAIL move_up_open_time: got %0d expected 15", open_t); end
      checks++;
      if (elevators_location !== 6'b000_011 || doors_status !== 2'b10) begin
         errors++; $display("FAIL move_up_final: got loc %b doors %b expected 000011 10", elevators_location, doors_status);
      end
   endtask

   task automatic test_request_clear();
      cabin_btn[5] = 1'b1; tick(); cabin_btn = '0;
      checks++;
      if (requested_floors[5] !== 1'b1 || dut_vec !== exp_vec()) begin
         errors++; $display("FAIL req_latch: got %h expected %h", dut_vec, exp_vec());
      end
      for (int k = 0; k < 60 && !(m_loc[0] == 5 && m_door[0] == D_OPEN); k++) begin
         up[0] = (m_door[0] == D_CLOSED) && m_loc[0] < 4;
         stop[0] = (m_loc[0] == 4) && m_dir[0] != 0 && !m_pend[0];
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL req_travel: got %h expected %h", dut_vec, exp_vec()); end
      end
      up = '0; stop = '0;
      checks++;
      if (requested_floors[5] !== 1'b0 || elevators_location[2:0] !== 3'd5) begin
         errors++; $display("FAIL req_clear: got req5 %b loc %0d expected 0 5", requested_floors[5], elevators_location[2:0]);
      end
      for (int k = 0; k < 20 && m_door[0] != D_CLOSED; k++) tick();
      up[0] = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL top_floor_up: got %h expected %h", dut_vec, exp_vec()); end
      end
      up = '0;
      checks++;
      if (elevators_location[2:0] !== 3'd5 || doors_status[0] !== 1'b1) begin
         errors++; $display("FAIL top_floor_hold: got loc %0d door %b expected 5 1", elevators_location[2:0], doors_status[0]);
      end
   endtask

   task automatic test_stop_midtransit();
      for (int k = 0; k < 60 && !(m_loc[0] == 2 && m_door[0] == D_OPEN); k++) begin
         down[0] = (m_door[0] == D_CLOSED) && m_loc[0] > 3;
         stop[0] = (m_loc[0] == 3) && m_dir[0] != 0 && !m_pend[0];
         tick();
      end
      down = '0; stop = '0;
      for (int k = 0; k < 20 && m_door[0] != D_CLOSED; k++) tick();
      up[0] = 1'b1; tick(); up[0] = 1'b0;
      stop[0] = 1'b1; tick(); stop[0] = 1'b0;
      for (int k = 0; k < 20 && m_door[0] != D_OPEN; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL stop_transit: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (elevators_location[2:0] !== 3'd3 || doors_status[0] !== 1'b0) begin
         errors++; $display("FAIL stop_transit_arrive: got loc %0d door %b expected 3 0", elevators_location[2:0], doors_status[0]);
      end
      for (int k = 0; k < 20 && m_door[0] != D_CLOSING; k++) tick();
      cabin_btn[3] = 1'b1; tick(); cabin_btn = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reopen: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (doors_status[0] !== 1'b0 || requested_floors[3] !== 1'b0) begin
         errors++; $display("FAIL reopen_state: got door %b req3 %b expected 0 0", doors_status[0], requested_floors[3]);
      end
      for (int k = 0; k < 20 && m_door[0] != D_CLOSED; k++) tick();
   endtask

   task automatic test_conflict();
      @(negedge clk); rst_n = 1'b0; #2; model_reset();
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 10 && !(m_door[0] == D_CLOSED && m_door[1] == D_CLOSED); k++) tick();
      up = 2'b11; down = 2'b01;
      for (int k = 0; k < 13; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL conflict: got %h expected %h", dut_vec, exp_vec()); end
      end
      checks++;
      if (elevators_location !== 6'b011_000) begin
         errors++; $display("FAIL conflict_loc: got %b expected 011000", elevators_location);
      end
      up = '0; down = '0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 5) == 0) up = 2'($urandom);
         if ($urandom_range(0, 5) == 0) down = 2'($urandom);
         stop = {1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0)};
         cabin_btn = ($urandom_range(0, 3) == 0) ? (12'd1 << $urandom_range(0, 11)) : 12'd0;
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random k=%0d: got %h expected %h", k, dut_vec, exp_vec()); end
      end
      up = '0; down = '0; stop = '0; cabin_btn = '0;
   endtask

   task automatic test_async_reset();
      @(negedge clk); rst_n = 1'b0; #2; model_reset();
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 10 && m_door[0] != D_CLOSED; k++) tick();
      up[0] = 1'b1; cabin_btn[5] = 1'b1; tick(); cabin_btn = '0;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (dut_vec !== exp_vec() || elevators_location[2:0] !== 3'd1) begin
         errors++; $display("FAIL pre_reset: got %h expected %h", dut_vec, exp_vec());
      end
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      checks++;
      if (dut_vec !== '0) begin errors++; $display("FAIL async_reset: got %h expected 0", dut_vec); end
      model_reset(); up = '0;
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset: got %h expected %h", dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_move_up();
      test_request_clear();
      test_stop_midtransit();
      test_conflict();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/elevator_car_plant.md
Name: elevator_car_plant

Overview:
- Car-side counterpart of MainController in the two-car elevator system.
- Consumes the per-car up/down/stop commands and models each car's motion, doors and cabin-button latching.
- Produces elevators_location, doors_status and requested_floors, the buses MainController reads.
- Replaces the hand-written location/door stimulus in benches; becomes the plant model for closed-loop system simulation.

Parameters:
- NUM_FLOORS, 6 (sys_pkg): floors per car; also the location bus width (two LOC_W = NUM_FLOORS/2 = 3-bit fields).
- TRAVEL_CYCLES, 8: clocks to move one floor.
- DOOR_CYCLES, 4: clocks to fully open or fully close a door.
- DWELL_CYCLES, 10: clocks a door stays fully open.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- up  in  2  bit i: command car i to move up (level).
- down  in  2  bit i: command car i to move down (level).
- stop  in  2  bit i: command car i to stop at the next floor and open its door (level).
- cabin_btn  in  2*NUM_FLOORS  car i floor f button at bit i*NUM_FLOORS+f; single-cycle pulses.
- elevators_location  out  NUM_FLOORS  car i binary floor at [i*LOC_W +: LOC_W].
- doors_status  out  2  bit i = 1 when car i door is fully closed.
- requested_floors  out  2*NUM_FLOORS  latched cabin requests, same packing as cabin_btn.

Behaviour:
- Interface clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- Two identical, independent car instances; all outputs registered.
- Reset values:
  - location = 0.
  - requested_floors = 0.
  - doors_status = 0 (doors open).
  - state = DOOR_OPEN with the dwell counter loaded with DWELL_CYCLES.
- States: DOOR_OPEN, DOOR_CLOSING, IDLE_CLOSED, MOVING_UP, MOVING_DOWN, DOOR_OPENING.
- doors_status = 1 only in IDLE_CLOSED, MOVING_UP and MOVING_DOWN.
- Command priority: stop > up > down. up && down with no stop is treated as no command. Commands are sampled every clock.
- DOOR_OPEN:
  - Counter decrements; at 0, go to DOOR_CLOSING.
  - A cabin press for the current floor reloads the dwell counter and is not latched.
- DOOR_CLOSING (DOOR_CYCLES clocks):
  - A current-floor cabin press or stop reverses to DOOR_OPENING.
  - On completion, go to IDLE_CLOSED.
- IDLE_CLOSED:
  - stop -> DOOR_OPENING.
  - up and location < NUM_FLOORS-1 -> MOVING_UP.
  - down and location > 0 -> MOVING_DOWN.
  - Otherwise hold.
- MOVING_x:
  - Entry loads the travel counter with TRAVEL_CYCLES-1.
  - At 0, location updates by ±1 (visible the next cycle).
  - Then: stop -> DOOR_OPENING; same-direction command still active and not at the end floor -> reload and continue; else -> IDLE_CLOSED.
  - A car never halts between floors; stop mid-transit takes effect at arrival.
  - A reversed command mid-transit is ignored until arrival.
- DOOR_OPENING: runs DOOR_CYCLES clocks, then DOOR_OPEN.
- Request clearing: on entry to DOOR_OPEN, clear the requested_floors bit of the current floor.
- Request latching:
  - A cabin press sets its bit one clock later, except when it is for the current floor with the door open or opening.
  - A set and a clear hitting the same bit in the same cycle: the clear wins.
- End floors: up at floor NUM_FLOORS-1 and down at floor 0 are ignored; location never wraps.
- Reset mid-motion aborts immediately to the reset state (location 0).
- Counter width: $clog2 of the largest cycle parameter, plus 1.

Decomposition:
- sys_pkg additions:
  - NUM_CARS = 2.
  - LOC_W = NUM_FLOORS/2.
  - car_state_t enum.
  - Default TRAVEL/DOOR/DWELL constants.
- Sub-module elevator_car: one car (FSM, counters, request latch).
- elevator_car_plant: instantiates elevator_car twice and packs/unpacks the buses.

Test Plan (bench uses TRAVEL_CYCLES=4, DOOR_CYCLES=2, DWELL_CYCLES=3):
1. Reset → location=0, doors_status=00, requested_floors=0. Check the door closes within 3+2 clocks → doors_status=11.
2. up[0] held from idle until location[2:0]=3, then stop[0] → location steps 1,2,3, one step every 4 clocks. Door opens 2 clocks after arrival; doors_status[0]=0; car 1 unaffected.
3. cabin_btn bit 5 (car 0, floor 5) pulsed → requested_floors[5]=1 next clock. Drive up to floor 5 with stop → bit clears on DOOR_OPEN entry. A further up at floor 5 is ignored; location stays 5.
4. stop[0] asserted 1 clock into a transit from floor 2 → car still reaches floor 3, then opens. Press for floor 3 during DOOR_CLOSING → reopens; requested bit stays 0.
5. up=11 and down=01 together → car 0 holds (conflict). Car 1 moves up, both idle at floor 0.
6. rst_n asserted asynchronously mid-transit → outputs return to reset values before the next clk edge.
